alu_issue_scheduler: RTL and testbench

Out-of-order issue buffer and arbiter for the ALU in the Tomasulo core. It holds up to DEPTH dispatched ALU/branch micro-ops and snoops the two common data buses to capture operand values. Each cycle it selects the oldest entry whose operands are both available and drives it into the combinational ALU through registered outputs. It sits between the dispatcher/ROB and the ALU and discards all contents on a ROB flush.

---
 rtl/alu_issue_scheduler_if.sv | 59 +++++
 rtl/alu_issue_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_alu_issue_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_scheduler_if.sv
// Interface bundling the dispatch, CDB snoop, flush and ALU issue signals
// of the ALU issue scheduler.
interface alu_issue_scheduler_if #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
);
  // dispatch side
  logic             disp_valid_in;
  logic [OP_W-1:0]  disp_op_in;
  logic [31:0]      disp_imm_in;
  logic [31:0]      disp_pc_in;
  logic             disp_q1_busy_in;
  logic             disp_q2_busy_in;
  logic [TAG_W-1:0] disp_q1_in;
  logic [TAG_W-1:0] disp_q2_in;
  logic [31:0]      disp_v1_in;
  logic [31:0]      disp_v2_in;
  logic [TAG_W-1:0] disp_dest_in;
  logic             full_out;
  // common data buses (cdb0 = ALU, cdb1 = LSB)
  logic             cdb0_valid_in;
  logic [TAG_W-1:0] cdb0_tag_in;
  logic [31:0]      cdb0_value_in;
  logic             cdb1_valid_in;
  logic [TAG_W-1:0] cdb1_tag_in;
  logic [31:0]      cdb1_value_in;
  // ROB rollback
  logic             rob_flush_in;
  // ALU issue
  logic             alu_calc_out;
  logic [OP_W-1:0]  alu_op_out;
  logic [31:0]      alu_imm_out;
  logic [31:0]      alu_pc_out;
  logic [31:0]      alu_rs1val_out;
  logic [31:0]      alu_rs2val_out;
  logic [TAG_W-1:0] alu_dest_out;

  // master: dispatcher / ROB / CDB environment
  modport master (
    output disp_valid_in, disp_op_in, disp_imm_in, disp_pc_in,
           disp_q1_busy_in, disp_q2_busy_in, disp_q1_in, disp_q2_in,
           disp_v1_in, disp_v2_in, disp_dest_in,
           cdb0_valid_in, cdb0_tag_in, cdb0_value_in,
           cdb1_valid_in, cdb1_tag_in, cdb1_value_in, rob_flush_in,
    input  full_out, alu_calc_out, alu_op_out, alu_imm_out, alu_pc_out,
           alu_rs1val_out, alu_rs2val_out, alu_dest_out
  );

  // slave: the scheduler itself
  modport slave (
    input  disp_valid_in, disp_op_in, disp_imm_in, disp_pc_in,
           disp_q1_busy_in, disp_q2_busy_in, disp_q1_in, disp_q2_in,
           disp_v1_in, disp_v2_in, disp_dest_in,
           cdb0_valid_in, cdb0_tag_in, cdb0_value_in,
           cdb1_valid_in, cdb1_tag_in, cdb1_value_in, rob_flush_in,
    output full_out, alu_calc_out, alu_op_out, alu_imm_out, alu_pc_out,
           alu_rs1val_out, alu_rs2val_out, alu_dest_out
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Out-of-order ALU issue buffer: holds dispatched micro-ops, snoops both
// CDBs for pending operands and issues the oldest ready entry per cycle
// through registered ALU outputs. Age is tracked with an age matrix.
module alu_issue_scheduler #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  alu_issue_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] dest;
    logic             b1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v1;
    logic             b2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      v2;
  } entry_t;

  // Returns {busy, value} after snooping both CDBs; cdb0 wins a double hit.
  function automatic logic [32:0] snoop(
    input logic busy, input logic [TAG_W-1:0] tag, input logic [31:0] val,
    input logic c0v, input logic [TAG_W-1:0] c0t, input logic [31:0] c0d,
    input logic c1v, input logic [TAG_W-1:0] c1t, input logic [31:0] c1d);
    logic [32:0] res;
    res = {busy, val};
    if (busy) begin
      if (c0v && c0t == tag)      res = {1'b0, c0d};
      else if (c1v && c1t == tag) res = {1'b0, c1d};
    end
    return res;
  endfunction

  entry_t                      r_ent [DEPTH];
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][DEPTH-1:0] r_older;  // r_older[i][j]: entry i is older than j
  logic [CNT_W-1:0]            r_count;
  logic                        r_full;
  logic                        r_calc;
  logic [OP_W-1:0]             r_alu_op;
  logic [31:0]                 r_alu_imm;
  logic [31:0]                 r_alu_pc;
  logic [31:0]                 r_alu_rs1;
  logic [31:0]                 r_alu_rs2;
  logic [TAG_W-1:0]            r_alu_dest;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_sel;
  logic [IDX_W-1:0] w_sel_idx;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_issue;
  logic             w_disp;
  logic [CNT_W-1:0] w_count_nxt;
  entry_t           w_new;
  entry_t           w_iss;
  logic [32:0]      w_wk1 [DEPTH];
  logic [32:0]      w_wk2 [DEPTH];
  logic [32:0]      w_byp1;
  logic [32:0]      w_byp2;

  // Ready vector from registered state only, then oldest-ready select.
  always_comb begin
    w_ready = '0;
    w_sel   = '0;
    for (int i = 0; i < DEPTH; i++)
      w_ready[i] = r_valid[i] && !r_ent[i].b1 && !r_ent[i].b2;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (w_ready[j] && r_older[j][i]) w_sel[i] = 1'b0;
    end
  end

  // Encode the one-hot select and find the lowest free slot.
  always_comb begin
    w_sel_idx  = '0;
    w_free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_sel[i]) w_sel_idx = IDX_W'(i);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
  end

  // CDB snoop for resident entries and same-cycle bypass for the dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = snoop(r_ent[i].b1, r_ent[i].t1, r_ent[i].v1,
                       bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_value_in,
                       bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_value_in);
      w_wk2[i] = snoop(r_ent[i].b2, r_ent[i].t2, r_ent[i].v2,
                       bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_value_in,
                       bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_value_in);
    end
    w_byp1 = snoop(bus.disp_q1_busy_in, bus.disp_q1_in, bus.disp_v1_in,
                   bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_value_in,
                   bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_value_in);
    w_byp2 = snoop(bus.disp_q2_busy_in, bus.disp_q2_in, bus.disp_v2_in,
                   bus.cdb0_valid_in, bus.cdb0_tag_in, bus.cdb0_value_in,
                   bus.cdb1_valid_in, bus.cdb1_tag_in, bus.cdb1_value_in);
    w_new      = '0;
    w_new.op   = bus.disp_op_in;
    w_new.imm  = bus.disp_imm_in;
    w_new.pc   = bus.disp_pc_in;
    w_new.dest = bus.disp_dest_in;
    w_new.t1   = bus.disp_q1_in;
    w_new.t2   = bus.disp_q2_in;
    {w_new.b1, w_new.v1} = w_byp1;
    {w_new.b2, w_new.v2} = w_byp2;
  end

  assign w_iss       = r_ent[w_sel_idx];
  assign w_issue     = rdy_in && !bus.rob_flush_in && (|w_sel);
  assign w_disp      = bus.disp_valid_in && !r_full && rdy_in && !bus.rob_flush_in;
  assign w_count_nxt = r_count + CNT_W'(w_disp) - CNT_W'(w_issue);

  // Entry storage, age matrix, occupancy and registered ALU issue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_valid    <= '0;
      r_older    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_calc     <= 1'b0;
      r_alu_op   <= '0;
      r_alu_imm  <= '0;
      r_alu_pc   <= '0;
      r_alu_rs1  <= '0;
      r_alu_rs2  <= '0;
      r_alu_dest <= '0;
    end else if (bus.rob_flush_in) begin
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_calc  <= 1'b0;
    end else if (!rdy_in) begin
      r_calc <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i]) begin
          {r_ent[i].b1, r_ent[i].v1} <= w_wk1[i];
          {r_ent[i].b2, r_ent[i].v2} <= w_wk2[i];
        end
      end
      r_calc <= w_issue;
      if (w_issue) begin
        r_valid[w_sel_idx] <= 1'b0;
        r_alu_op   <= w_iss.op;
        r_alu_imm  <= w_iss.imm;
        r_alu_pc   <= w_iss.pc;
        r_alu_rs1  <= w_iss.v1;
        r_alu_rs2  <= w_iss.v2;
        r_alu_dest <= w_iss.dest;
      end
      // The free slot is never the issuing slot, so these writes are disjoint.
      if (w_disp) begin
        r_valid[w_free_idx] <= 1'b1;
        r_ent[w_free_idx]   <= w_new;
        for (int j = 0; j < DEPTH; j++) begin
          r_older[w_free_idx][j] <= 1'b0;
          r_older[j][w_free_idx] <= r_valid[j];
        end
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  assign bus.full_out       = r_full;
  assign bus.alu_calc_out   = r_calc;
  assign bus.alu_op_out     = r_alu_op;
  assign bus.alu_imm_out    = r_alu_imm;
  assign bus.alu_pc_out     = r_alu_pc;
  assign bus.alu_rs1val_out = r_alu_rs1;
  assign bus.alu_rs2val_out = r_alu_rs2;
  assign bus.alu_dest_out   = r_alu_dest;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed self-checking bench for alu_issue_scheduler.
module tb_alu_issue_scheduler;
  logic clk;
  logic rst;
  logic rdy;
  int   vectors;
  int   miscompares;

  alu_issue_scheduler_if #(.TAG_W(4), .OP_W(6)) bus ();

  alu_issue_scheduler #(.DEPTH(8), .TAG_W(4), .OP_W(6)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.disp_valid_in   = 1'b0;
    bus.disp_op_in      = '0;
    bus.disp_imm_in     = '0;
    bus.disp_pc_in      = '0;
    bus.disp_q1_busy_in = 1'b0;
    bus.disp_q2_busy_in = 1'b0;
    bus.disp_q1_in      = '0;
    bus.disp_q2_in      = '0;
    bus.disp_v1_in      = '0;
    bus.disp_v2_in      = '0;
    bus.disp_dest_in    = '0;
    bus.cdb0_valid_in   = 1'b0;
    bus.cdb0_tag_in     = '0;
    bus.cdb0_value_in   = '0;
    bus.cdb1_valid_in   = 1'b0;
    bus.cdb1_tag_in     = '0;
    bus.cdb1_value_in   = '0;
    bus.rob_flush_in    = 1'b0;
    rdy                 = 1'b1;
  endtask

  // Present one dispatch request; imm and pc are derived from dest.
  task automatic disp(input logic [3:0] dest, input logic b1, input logic [3:0] q1,
                      input logic [31:0] v1, input logic b2, input logic [3:0] q2,
                      input logic [31:0] v2);
    bus.disp_valid_in   = 1'b1;
    bus.disp_op_in      = 6'h13;
    bus.disp_imm_in     = 32'h1000 + 32'(dest);
    bus.disp_pc_in      = 32'h400 + 32'(dest) * 4;
    bus.disp_dest_in    = dest;
    bus.disp_q1_busy_in = b1;
    bus.disp_q1_in      = q1;
    bus.disp_v1_in      = v1;
    bus.disp_q2_busy_in = b2;
    bus.disp_q2_in      = q2;
    bus.disp_v2_in      = v2;
  endtask

  task automatic cdb0(input logic [3:0] t, input logic [31:0] v);
    bus.cdb0_valid_in = 1'b1;
    bus.cdb0_tag_in   = t;
    bus.cdb0_value_in = v;
  endtask

  task automatic cdb1(input logic [3:0] t, input logic [31:0] v);
    bus.cdb1_valid_in = 1'b1;
    bus.cdb1_tag_in   = t;
    bus.cdb1_value_in = v;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    clr();
    #1 rst = 1'b1;
    #2;
    // reset state
    chk("rst_calc", bus.alu_calc_out, 0);
    chk("rst_full", bus.full_out, 0);
    chk("rst_data", {bus.alu_rs1val_out, bus.alu_rs2val_out}, 0);
    chk("rst_misc", {bus.alu_op_out, bus.alu_dest_out, bus.alu_imm_out[7:0]}, 0);
    #4 rst = 1'b0;
    tick();

    // single ready dispatch: visible after edge k+1
    disp(4'd1, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    tick(); clr();
    chk("basic_k", bus.alu_calc_out, 0);
    tick();
    chk("basic_calc", bus.alu_calc_out, 1);
    chk("basic_dest", bus.alu_dest_out, 1);
    chk("basic_ops", {bus.alu_rs1val_out, bus.alu_rs2val_out}, {32'd5, 32'd7});
    chk("basic_pcimm", {bus.alu_pc_out, bus.alu_imm_out}, {32'h404, 32'h1001});
    chk("basic_op", bus.alu_op_out, 6'h13);
    tick();
    chk("basic_pulse", bus.alu_calc_out, 0);

    // oldest-first: A waits on tag 7, B and C ready
    disp(4'd3, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd1); tick();
    disp(4'd4, 1'b0, 4'd0, 32'h44, 1'b0, 4'd0, 32'd2); tick();
    disp(4'd5, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'd3); tick();
    clr();
    chk("ord_B", {bus.alu_calc_out, bus.alu_dest_out, bus.alu_rs1val_out}, {1'b1, 4'd4, 32'h44});
    tick();
    chk("ord_C", {bus.alu_calc_out, bus.alu_dest_out, bus.alu_rs1val_out}, {1'b1, 4'd5, 32'h55});
    tick();
    chk("ord_idle", bus.alu_calc_out, 0);
    cdb1(4'd7, 32'h10); tick(); clr();
    chk("ord_wake_k", bus.alu_calc_out, 0);
    tick();
    chk("ord_A", {bus.alu_calc_out, bus.alu_dest_out, bus.alu_rs1val_out}, {1'b1, 4'd3, 32'h10});
    tick();

    // same-cycle dispatch bypass from cdb0
    disp(4'd6, 1'b0, 4'd0, 32'd1, 1'b1, 4'd2, 32'd0);
    cdb0(4'd2, 32'hDEAD);
    tick(); clr(); tick();
    chk("byp", {bus.alu_calc_out, bus.alu_dest_out, bus.alu_rs2val_out}, {1'b1, 4'd6, 32'hDEAD});
    tick();

    // double CDB hit on a resident entry: cdb0 wins
    disp(4'd7, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0); tick(); clr();
    cdb0(4'd9, 32'hA0); cdb1(4'd9, 32'hB0); tick(); clr(); tick();
    chk("prio", {bus.alu_calc_out, bus.alu_rs1val_out}, {1'b1, 32'hA0});
    tick();

    // fill 8 entries waiting on tag 15, then drain in order
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'(i));
      tick();
      if (i == 6) chk("fill_7_notfull", bus.full_out, 0);
    end
    chk("fill_full", bus.full_out, 1);
    disp(4'd9, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h99);
    tick(); clr();
    chk("fill_9th_full", {bus.full_out, bus.alu_calc_out}, {1'b1, 1'b0});
    cdb0(4'd15, 32'h100); tick(); clr();
    chk("fill_wake_k", bus.alu_calc_out, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain", {bus.alu_calc_out, bus.alu_dest_out, bus.alu_rs1val_out, bus.alu_rs2val_out},
          {1'b1, 4'(i), 32'h100, 32'(i)});
      if (i == 0) chk("drain_full_fall", bus.full_out, 0);
    end
    tick();
    chk("drain_no_9th", bus.alu_calc_out, 0);

    // flush: 5 busy + 1 ready pending, dispatch and CDB in the flush cycle
    for (int i = 0; i < 5; i++) begin
      disp(4'd10, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0); tick();
    end
    disp(4'd11, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1); tick();
    disp(4'd12, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd2);
    cdb0(4'd14, 32'h77);
    bus.rob_flush_in = 1'b1;
    tick(); clr();
    chk("flush_calc", bus.alu_calc_out, 0);
    chk("flush_full", bus.full_out, 0);
    chk("flush_hold", bus.alu_dest_out, 7);
    cdb0(4'd14, 32'h77); tick(); clr();
    chk("flush_none1", bus.alu_calc_out, 0);
    tick();
    chk("flush_none2", bus.alu_calc_out, 0);
    tick();
    chk("flush_none3", bus.alu_calc_out, 0);

    // rdy_in low with two ready entries
    disp(4'd1, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0); tick();
    disp(4'd2, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0); tick(); clr();
    cdb0(4'd13, 32'h5); tick(); clr();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_low", bus.alu_calc_out, 0);
    end
    rdy = 1'b1;
    tick();
    chk("rdy_first", {bus.alu_calc_out, bus.alu_dest_out}, {1'b1, 4'd1});
    tick();
    chk("rdy_second", {bus.alu_calc_out, bus.alu_dest_out}, {1'b1, 4'd2});
    tick();
    chk("rdy_idle", bus.alu_calc_out, 0);

    // reset mid-operation with 5 entries valid
    for (int i = 0; i < 5; i++) begin
      disp(4'd8, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0); tick();
    end
    clr();
    #2 rst = 1'b1;
    #1;
    chk("mrst_out", {bus.alu_calc_out, bus.full_out, bus.alu_dest_out, bus.alu_rs1val_out}, 0);
    rst = 1'b0;
    disp(4'd9, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'h9);
    cdb0(4'd12, 32'h1);
    tick(); clr();
    chk("mrst_full", {bus.full_out, bus.alu_calc_out}, 0);
    tick();
    chk("mrst_issue", {bus.alu_calc_out, bus.alu_dest_out}, {1'b1, 4'd9});
    tick();
    chk("mrst_gone", bus.alu_calc_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
